// File: rtl/pipe_ctrl_pkg.sv
// Purpose: shared constants, state encoding and redirect decode for the pipeline sequencer.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

    // Bit positions inside the stall vector, upstream to downstream.
    localparam int STALL_PC  = 0;
    localparam int STALL_IF  = 1;
    localparam int STALL_ID  = 2;
    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    // MEM-stage exception codes.
    localparam logic [31:0] EXC_INT  = 32'h0000_0001;
    localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
    localparam logic [31:0] EXC_BRK  = 32'h0000_0009;
    localparam logic [31:0] EXC_RI   = 32'h0000_000a;
    localparam logic [31:0] EXC_OV   = 32'h0000_000c;
    localparam logic [31:0] EXC_TR   = 32'h0000_000d;
    localparam logic [31:0] EXC_ERET = 32'h0000_000e;

    // Stall vectors: the requesting stage and everything upstream of it hold.
    localparam logic [5:0] STALL_VEC_NONE = 6'b000000;
    localparam logic [5:0] STALL_VEC_IF   = 6'b000011;
    localparam logic [5:0] STALL_VEC_ID   = 6'b000111;
    localparam logic [5:0] STALL_VEC_EX   = 6'b001111;
    localparam logic [5:0] STALL_VEC_MEM  = 6'b011111;
    localparam logic [5:0] STALL_VEC_ALL  = 6'b111111;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_EXC_WAIT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_t;

    // ERET returns to EPC; every other nonzero code goes to the common vector.
    function automatic logic [31:0] decode_new_pc(input logic [31:0] code,
                                                  input logic [31:0] epc,
                                                  input logic [31:0] vec);
        logic [31:0] pc;
        pc = ZeroWord;
        if (code == EXC_ERET)
            pc = epc;
        else if (code != ZeroWord)
            pc = vec;
        return pc;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Purpose: bundle of stall requests, exception report and sequencer outputs.
// Latency: n/a (wiring only).
// Backpressure: n/a; master drives requests, slave (pipe_ctrl) drives stall/flush/new_pc/counters.
interface pipe_ctrl_if #(
    parameter int CNT_W = 32
);
    logic              stallreq_if;
    logic              stallreq_id;
    logic              stallreq_ex;
    logic              stallreq_mem;
    logic [31:0]       excepttype;
    logic [31:0]       cp0_epc;
    logic [5:0]        stall;
    logic              flush;
    logic [31:0]       new_pc;
    logic [CNT_W-1:0]  perf_stall_cycles;
    logic [15:0]       perf_flush_count;

    modport master (
        output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        output excepttype, cp0_epc,
        input  stall, flush, new_pc, perf_stall_cycles, perf_flush_count
    );

    modport slave (
        input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        input  excepttype, cp0_epc,
        output stall, flush, new_pc, perf_stall_cycles, perf_flush_count
    );
endinterface

// File: rtl/pipe_ctrl_perf.sv
// Purpose: stall-cycle and flush-pulse performance counters (free-running, wrapping).
// Latency: counters reflect a cycle's stall/flush one clock after that cycle.
// Backpressure: none; counts every qualifying cycle.
// Ports: clk, rst (sync active-low), i_stall_pc, i_flush in; o_perf_stall_cycles[CNT_W], o_perf_flush_count[16] out.
module pipe_ctrl_perf #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_stall_pc,
    input  logic             i_flush,
    output logic [CNT_W-1:0] o_perf_stall_cycles,
    output logic [15:0]      o_perf_flush_count
);
    logic [CNT_W-1:0] r_stall_cycles;
    logic [15:0]      r_flush_count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (i_stall_pc)
                r_stall_cycles <= r_stall_cycles + 1'b1;
            if (i_flush)
                r_flush_count <= r_flush_count + 16'd1;
        end
    end

    assign o_perf_stall_cycles = r_stall_cycles;
    assign o_perf_flush_count  = r_flush_count;
endmodule

// File: rtl/pipe_ctrl.sv
// Purpose: pipeline sequencer - stall vector, flush pulse and redirect PC for the 5-stage core.
// Latency: stall/flush/new_pc are combinational (zero latency); deferred exceptions flush one cycle after IF bus completes.
// Backpressure: an exception seen while the instruction bus is mid-handshake freezes the whole pipe until it completes.
// Ports: clk, rst (sync active-low), bus (pipe_ctrl_if.slave: stallreq_*, excepttype, cp0_epc in; stall, flush, new_pc, perf_* out).
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
    parameter int          CNT_W      = 32
) (
    input  logic      clk,
    input  logic      rst,
    pipe_ctrl_if.slave bus
);
    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_exc_type;
    logic [31:0] r_exc_epc;
    logic        w_latch_exc;
    logic [5:0]  w_stall;
    logic        w_flush;
    logic [31:0] w_new_pc;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_RUN;
            r_exc_type <= ZeroWord;
            r_exc_epc  <= ZeroWord;
        end else begin
            r_state <= w_state_nxt;
            if (w_latch_exc) begin
                r_exc_type <= bus.excepttype;
                r_exc_epc  <= bus.cp0_epc;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_stall     = STALL_VEC_NONE;
        w_flush     = 1'b0;
        w_new_pc    = ZeroWord;
        w_latch_exc = 1'b0;

        // Outputs stay quiet for the whole reset cycle.
        if (rst) begin
            unique case (r_state)
                ST_RUN: begin
                    if (bus.excepttype != ZeroWord) begin
                        if (!bus.stallreq_if) begin
                            w_flush  = 1'b1;
                            w_new_pc = decode_new_pc(bus.excepttype, bus.cp0_epc, EXC_VECTOR);
                        end else begin
                            // Fetch is mid-handshake: freeze everything and remember
                            // the exception so the bus transaction can finish.
                            w_stall     = STALL_VEC_ALL;
                            w_latch_exc = 1'b1;
                            w_state_nxt = ST_EXC_WAIT;
                        end
                    end else if (bus.stallreq_mem) begin
                        w_stall = STALL_VEC_MEM;
                    end else if (bus.stallreq_ex) begin
                        w_stall = STALL_VEC_EX;
                    end else if (bus.stallreq_id) begin
                        w_stall = STALL_VEC_ID;
                    end else if (bus.stallreq_if) begin
                        w_stall = STALL_VEC_IF;
                    end
                end
                ST_EXC_WAIT: begin
                    // Frozen pipe: live excepttype is stale/irrelevant here.
                    w_stall = STALL_VEC_ALL;
                    if (!bus.stallreq_if)
                        w_state_nxt = ST_FLUSH;
                end
                ST_FLUSH: begin
                    w_flush     = 1'b1;
                    w_new_pc    = decode_new_pc(r_exc_type, r_exc_epc, EXC_VECTOR);
                    w_state_nxt = ST_RUN;
                end
                default: begin
                    w_state_nxt = ST_RUN;
                end
            endcase
        end
    end

    assign bus.stall  = w_stall;
    assign bus.flush  = w_flush;
    assign bus.new_pc = w_new_pc;

    pipe_ctrl_perf #(
        .CNT_W (CNT_W)
    ) u_perf (
        .clk                 (clk),
        .rst                 (rst),
        .i_stall_pc          (w_stall[STALL_PC] == Stop),
        .i_flush             (w_flush),
        .o_perf_stall_cycles (bus.perf_stall_cycles),
        .o_perf_flush_count  (bus.perf_flush_count)
    );
endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    pipe_ctrl_if #(.CNT_W(32)) bus  ();
    pipe_ctrl_if #(.CNT_W(4))  bus4 ();

    pipe_ctrl #(.EXC_VECTOR(32'h0000_0020), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    pipe_ctrl #(.EXC_VECTOR(32'h0000_0020), .CNT_W(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    // The narrow-counter instance sees exactly the same stimulus.
    assign bus4.stallreq_if  = bus.stallreq_if;
    assign bus4.stallreq_id  = bus.stallreq_id;
    assign bus4.stallreq_ex  = bus.stallreq_ex;
    assign bus4.stallreq_mem = bus.stallreq_mem;
    assign bus4.excepttype   = bus.excepttype;
    assign bus4.cp0_epc      = bus.cp0_epc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.stallreq_if  = 1'b0;
        bus.stallreq_id  = 1'b0;
        bus.stallreq_ex  = 1'b0;
        bus.stallreq_mem = 1'b0;
        bus.excepttype   = 32'h0;
        bus.cp0_epc      = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.stallreq_if  = 1'b1;
        bus.stallreq_id  = 1'b1;
        bus.stallreq_ex  = 1'b1;
        bus.stallreq_mem = 1'b1;
        bus.excepttype   = 32'h8;
        bus.cp0_epc      = 32'h44;
        for (int c = 0; c < 2; c++) begin
            #1;
            total++; if (bus.stall !== 6'b000000) begin bad++; $display("FAIL reset_stall c%0d got=%b want=000000", c, bus.stall); end
            total++; if (bus.flush !== 1'b0) begin bad++; $display("FAIL reset_flush c%0d got=%b want=0", c, bus.flush); end
            total++; if (bus.new_pc !== 32'h0) begin bad++; $display("FAIL reset_new_pc c%0d got=%h want=0", c, bus.new_pc); end
            step();
        end
        quiet();
        rst = 1'b1;
        #1;
        total++; if (bus.perf_stall_cycles !== 32'd0) begin bad++; $display("FAIL reset_stall_cnt got=%0d want=0", bus.perf_stall_cycles); end
        total++; if (bus.perf_flush_count !== 16'd0) begin bad++; $display("FAIL reset_flush_cnt got=%0d want=0", bus.perf_flush_count); end
        total++; if (bus.stall !== 6'b000000 || bus.flush !== 1'b0) begin bad++; $display("FAIL reset_idle stall=%b flush=%b want 000000/0", bus.stall, bus.flush); end
        step();
    endtask

    task automatic test_priority();
        bus.stallreq_id  = 1'b1;
        bus.stallreq_mem = 1'b1;
        #1;
        total++; if (bus.stall !== 6'b011111) begin bad++; $display("FAIL prio_mem_id got=%b want=011111", bus.stall); end
        step();
        bus.stallreq_mem = 1'b0;
        #1;
        total++; if (bus.stall !== 6'b000111) begin bad++; $display("FAIL prio_id got=%b want=000111", bus.stall); end
        step();
        bus.stallreq_ex = 1'b1;
        bus.stallreq_if = 1'b1;
        bus.stallreq_id = 1'b0;
        #1;
        total++; if (bus.stall !== 6'b001111) begin bad++; $display("FAIL prio_ex_if got=%b want=001111", bus.stall); end
        bus.stallreq_ex = 1'b0;
        #1;
        total++; if (bus.stall !== 6'b000011) begin bad++; $display("FAIL prio_if got=%b want=000011", bus.stall); end
        bus.stallreq_if = 1'b0;
        #1;
        total++; if (bus.stall !== 6'b000000 || bus.flush !== 1'b0) begin bad++; $display("FAIL prio_none stall=%b flush=%b want 000000/0", bus.stall, bus.flush); end
        step();
        total++; if (bus.perf_stall_cycles !== 32'd2) begin bad++; $display("FAIL prio_stall_cnt got=%0d want=2", bus.perf_stall_cycles); end
    endtask

    task automatic test_immediate_exc();
        bus.excepttype  = 32'h8;
        bus.stallreq_ex = 1'b1;
        bus.stallreq_if = 1'b0;
        bus.cp0_epc     = 32'h300;
        #1;
        total++; if (bus.flush !== 1'b1) begin bad++; $display("FAIL imm_flush got=%b want=1", bus.flush); end
        total++; if (bus.stall !== 6'b000000) begin bad++; $display("FAIL imm_stall got=%b want=000000", bus.stall); end
        total++; if (bus.new_pc !== 32'h20) begin bad++; $display("FAIL imm_new_pc got=%h want=00000020", bus.new_pc); end
        step();
        quiet();
        #1;
        total++; if (bus.perf_flush_count !== 16'd1) begin bad++; $display("FAIL imm_flush_cnt got=%0d want=1", bus.perf_flush_count); end
        total++; if (bus.perf_stall_cycles !== 32'd2) begin bad++; $display("FAIL imm_stall_cnt got=%0d want=2", bus.perf_stall_cycles); end
        total++; if (bus.flush !== 1'b0 || bus.new_pc !== 32'h0) begin bad++; $display("FAIL imm_after flush=%b new_pc=%h want 0/0", bus.flush, bus.new_pc); end
        step();
    endtask

    task automatic test_deferred_eret();
        bus.stallreq_if = 1'b1;
        bus.excepttype  = 32'he;
        bus.cp0_epc     = 32'h100;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) begin
                bus.excepttype = 32'h0;
                bus.cp0_epc    = 32'h200;
            end
            if (c == 3)
                bus.stallreq_if = 1'b0;
            #1;
            total++; if (bus.stall !== 6'b111111 || bus.flush !== 1'b0) begin bad++; $display("FAIL eret_wait c%0d stall=%b flush=%b want 111111/0", c, bus.stall, bus.flush); end
            step();
        end
        #1;
        total++; if (bus.flush !== 1'b1 || bus.stall !== 6'b000000) begin bad++; $display("FAIL eret_flush flush=%b stall=%b want 1/000000", bus.flush, bus.stall); end
        total++; if (bus.new_pc !== 32'h100) begin bad++; $display("FAIL eret_new_pc got=%h want=00000100", bus.new_pc); end
        step();
        #1;
        total++; if (bus.flush !== 1'b0 || bus.stall !== 6'b000000 || bus.new_pc !== 32'h0) begin bad++; $display("FAIL eret_run flush=%b stall=%b new_pc=%h want 0/000000/0", bus.flush, bus.stall, bus.new_pc); end
        total++; if (bus.perf_flush_count !== 16'd2) begin bad++; $display("FAIL eret_flush_cnt got=%0d want=2", bus.perf_flush_count); end
        total++; if (bus.perf_stall_cycles !== 32'd6) begin bad++; $display("FAIL eret_stall_cnt got=%0d want=6", bus.perf_stall_cycles); end
        step();
    endtask

    task automatic test_short_wait();
        // IF completes in the very cycle after the exception: one EXC_WAIT cycle, then flush.
        bus.stallreq_if = 1'b1;
        bus.excepttype  = 32'h1;
        bus.cp0_epc     = 32'h400;
        #1;
        total++; if (bus.stall !== 6'b111111) begin bad++; $display("FAIL short_enter got=%b want=111111", bus.stall); end
        step();
        bus.stallreq_if = 1'b0;
        bus.excepttype  = 32'he;
        #1;
        total++; if (bus.stall !== 6'b111111 || bus.flush !== 1'b0) begin bad++; $display("FAIL short_wait stall=%b flush=%b want 111111/0", bus.stall, bus.flush); end
        step();
        bus.excepttype = 32'h0;
        #1;
        total++; if (bus.flush !== 1'b1 || bus.new_pc !== 32'h20) begin bad++; $display("FAIL short_flush flush=%b new_pc=%h want 1/00000020", bus.flush, bus.new_pc); end
        step();
        total++; if (bus.perf_flush_count !== 16'd3) begin bad++; $display("FAIL short_flush_cnt got=%0d want=3", bus.perf_flush_count); end
    endtask

    task automatic test_reset_abort();
        bus.stallreq_if = 1'b1;
        bus.excepttype  = 32'hc;
        #1;
        total++; if (bus.stall !== 6'b111111) begin bad++; $display("FAIL abort_enter got=%b want=111111", bus.stall); end
        step();
        quiet();
        rst = 1'b0;
        #1;
        total++; if (bus.flush !== 1'b0 || bus.stall !== 6'b000000) begin bad++; $display("FAIL abort_rst flush=%b stall=%b want 0/000000", bus.flush, bus.stall); end
        step();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++; if (bus.flush !== 1'b0 || bus.stall !== 6'b000000) begin bad++; $display("FAIL abort_run c%0d flush=%b stall=%b want 0/000000", c, bus.flush, bus.stall); end
            step();
        end
        total++; if (bus.perf_flush_count !== 16'd0) begin bad++; $display("FAIL abort_flush_cnt got=%0d want=0", bus.perf_flush_count); end
        total++; if (bus.perf_stall_cycles !== 32'd0) begin bad++; $display("FAIL abort_stall_cnt got=%0d want=0", bus.perf_stall_cycles); end
    endtask

    task automatic test_counter_wrap();
        bus.stallreq_if = 1'b1;
        for (int c = 0; c < 17; c++)
            step();
        bus.stallreq_if = 1'b0;
        #1;
        total++; if (bus4.perf_stall_cycles !== 4'd1) begin bad++; $display("FAIL wrap_cnt4 got=%0d want=1", bus4.perf_stall_cycles); end
        total++; if (bus.perf_stall_cycles !== 32'd17) begin bad++; $display("FAIL wrap_cnt32 got=%0d want=17", bus.perf_stall_cycles); end
        step();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        quiet();
        step();
        test_reset();
        test_priority();
        test_immediate_exc();
        test_deferred_eret();
        test_short_wait();
        test_reset_abort();
        test_counter_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the 5-stage MIPS core.
- Collects stall requests from IF (instruction bus wait), ID (load-use), EX (multi-cycle mult/div) and MEM (data bus wait), plus exception reports from the MEM stage.
- Produces the 6-bit stall vector and the flush pulse consumed by every pipeline latch and the PC register, and the redirect PC on exceptions/ERET.
- Sequences exceptions so that an in-flight instruction-bus transaction is never abandoned mid-handshake.

Parameters:
- EXC_VECTOR, 32'h0000_0020, redirect target for every exception except ERET
- CNT_W, 32, width of the stall-cycle performance counter

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-low (sampled on posedge clk; 0 = reset)
- stallreq_if  in  1  instruction bus has not completed its handshake
- stallreq_id  in  1  load-use hazard in ID
- stallreq_ex  in  1  EX multi-cycle operation busy
- stallreq_mem  in  1  data bus has not completed its handshake
- excepttype  in  32  MEM-stage exception code; 0 = none
- cp0_epc  in  32  current EPC from CP0
- stall  out  6  [0]=PC, [1]=IF, [2]=ID, [3]=EX, [4]=MEM, [5]=WB; 1 = hold
- flush  out  1  clear all pipeline latches this cycle
- new_pc  out  32  redirect target; valid only while flush=1, otherwise 0
- perf_stall_cycles  out  CNT_W  count of cycles with stall[0]=1
- perf_flush_count  out  16  count of flush pulses

Behaviour:
- Reset (rst=0 at posedge): state=RUN, latched type/EPC=0, both counters=0.
- Combinational outputs during reset cycles: stall=0, flush=0, new_pc=0.
- stall, flush and new_pc are combinational from state, latched regs and inputs. Zero latency: a request in cycle N affects the latches at the end of cycle N.
- Stall priority in RUN with no exception (highest requesting stage wins):
  - MEM -> 6'b011111
  - EX -> 6'b001111
  - ID -> 6'b000111
  - IF -> 6'b000011
  - none -> 0
  - Downstream latches insert bubbles per their own stall[k]/stall[k+1] rule.
- new_pc decode:
  - 32'h0000_000e (ERET) -> cp0_epc.
  - Any other nonzero code (1, 8, 9, a, c, d, ...) -> EXC_VECTOR.
- States:
  - RUN:
    - excepttype!=0 and stallreq_if=0 -> flush=1, stall=0, new_pc decoded from live inputs; stay RUN.
    - excepttype!=0 and stallreq_if=1 -> stall=6'b111111, flush=0; latch excepttype and cp0_epc; go EXC_WAIT.
    - Exception has priority over stallreq_id/ex/mem.
  - EXC_WAIT:
    - stall=6'b111111, flush=0.
    - New excepttype values are ignored (pipeline frozen).
    - When stallreq_if=0, go FLUSH next cycle.
  - FLUSH: flush=1, stall=0, new_pc decoded from latched values; go RUN unconditionally.
- Counters:
  - perf_stall_cycles increments every cycle stall[0]=1 and wraps at 2^CNT_W.
  - perf_flush_count increments every cycle flush=1 and wraps at 2^16.
- Boundary cases:
  - Reset mid-EXC_WAIT or mid-FLUSH drops the pending exception. No flush is emitted.
  - stallreq_if deasserting in the same cycle as entry to EXC_WAIT: EXC_WAIT still lasts at least one cycle.
  - flush and nonzero stall are never both active.

Decomposition:
- Shared package/defines:
  - stall bit indices (STALL_PC..STALL_WB)
  - Stop/NoStop
  - exception code constants (EXC_INT=1, EXC_SYS=8, EXC_BRK=9, EXC_RI=a, EXC_OV=c, EXC_TR=d, EXC_ERET=e)
  - ZeroWord
  - state encoding
- Sub-module pipe_ctrl_perf: holds both counters, driven by stall[0] and flush.

Test Plan:
- Reset: rst=0 for 2 cycles with all requests high -> stall=0, flush=0, new_pc=0, both counters=0.
- Priority: assert stallreq_id and stallreq_mem together -> stall=6'b011111. Drop mem -> 6'b000111. Drop all -> 0. perf_stall_cycles=2.
- Immediate exception: excepttype=32'h8, stallreq_ex=1, stallreq_if=0 -> same cycle flush=1, stall=0, new_pc=32'h20. perf_flush_count=1.
- Deferred ERET:
  - Stimulus: stallreq_if=1 for 3 cycles, excepttype=32'he with cp0_epc=32'h100 in cycle 0. Change excepttype to 0 and cp0_epc to 32'h200 at cycle 1.
  - Response: stall=6'b111111 for cycles 0-3, then one cycle of flush=1 with new_pc=32'h100, then RUN.
- Reset abort: enter EXC_WAIT, then rst=0 for one cycle -> state RUN, no flush pulse ever observed, perf_flush_count=0.
- Counter wrap: with CNT_W=4, hold stallreq_if=1 for 17 cycles -> perf_stall_cycles=1.
